// File: rtl/axi_lite_sram_slave_if.sv
// rtl/axi_lite_sram_slave_if.sv - AXI-Lite single-beat bus between a master and the SRAM slave
interface axi_lite_sram_slave_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_sram_slave.sv
// rtl/axi_lite_sram_slave.sv - AXI-Lite word RAM with byte strobes and wait states
// Define AXI_LITE_SRAM_DECERR_EN to answer out-of-range accesses with SLVERR.
module axi_lite_sram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_STATES = 0
) (
  input logic                  clk,
  input logic                  rst,
  axi_lite_sram_slave_if.slave axi_lite
);
  localparam int         IDX_W       = $clog2(DEPTH);
  localparam logic [3:0] WS_LAST     = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_DELAY, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_DELAY, R_RESP} r_state_t;

  logic [31:0] mem [DEPTH];

  w_state_t    w_state, w_next;
  logic        aw_got, w_got;
  logic [31:0] aw_addr_q, w_data_q;
  logic [3:0]  w_strb_q, w_cnt;
  logic [1:0]  bresp_q;
  logic        awready, wready, bvalid;
  logic        aw_hs, w_hs, have_aw, have_w;
  logic [31:0] wr_addr, wr_data, wr_off;
  logic [3:0]  wr_strb;
  logic [IDX_W-1:0] wr_idx;
  logic        wr_in_range, wr_commit;

  r_state_t    r_state, r_next;
  logic [31:0] ar_addr_q, rdata_q, rd_addr, rd_off;
  logic [3:0]  r_cnt;
  logic [1:0]  rresp_q;
  logic        arready, rvalid, ar_hs, rd_in_range, rd_commit;
  logic [IDX_W-1:0] rd_idx;
  logic        unused_bits;

  assign aw_hs   = axi_lite.awvalid && awready;
  assign w_hs    = axi_lite.wvalid && wready;
  assign have_aw = aw_got || aw_hs;
  assign have_w  = w_got || w_hs;

  // A half captured this very cycle is taken straight from the bus.
  assign wr_addr = aw_got ? aw_addr_q : axi_lite.awaddr;
  assign wr_data = w_got ? w_data_q : axi_lite.wdata;
  assign wr_strb = w_got ? w_strb_q : axi_lite.wstrb;
  assign wr_off  = wr_addr - BASE_ADDR;
  assign wr_idx  = wr_off[IDX_W+1:2];

  assign ar_hs   = axi_lite.arvalid && arready;
  assign rd_addr = (r_state == R_IDLE) ? axi_lite.araddr : ar_addr_q;
  assign rd_off  = rd_addr - BASE_ADDR;
  assign rd_idx  = rd_off[IDX_W+1:2];

`ifdef AXI_LITE_SRAM_DECERR_EN
  assign wr_in_range = (wr_off >> (IDX_W + 2)) == 32'd0;
  assign rd_in_range = (rd_off >> (IDX_W + 2)) == 32'd0;
`else
  assign wr_in_range = 1'b1;
  assign rd_in_range = 1'b1;
`endif
  assign unused_bits = ^{wr_off, rd_off};

  assign wr_commit = !rst && (w_next == W_RESP) && (w_state != W_RESP);
  assign rd_commit = !rst && (r_next == R_RESP) && (r_state != R_RESP);

  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE, W_COLLECT: begin
        if (have_aw && have_w)  w_next = (WAIT_STATES == 0) ? W_RESP : W_DELAY;
        else if (aw_hs || w_hs) w_next = W_COLLECT;
      end
      W_DELAY: if (w_cnt == WS_LAST) w_next = W_RESP;
      W_RESP:  if (axi_lite.bready)  w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    if (!rst) begin
      awready = ((w_state == W_IDLE) || (w_state == W_COLLECT)) && !aw_got;
      wready  = ((w_state == W_IDLE) || (w_state == W_COLLECT)) && !w_got;
      bvalid  = (w_state == W_RESP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      aw_addr_q <= 32'd0;
      w_data_q  <= 32'd0;
      w_strb_q  <= 4'd0;
      w_cnt     <= 4'd0;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_got    <= 1'b1;
        aw_addr_q <= axi_lite.awaddr;
      end
      if (w_hs) begin
        w_got    <= 1'b1;
        w_data_q <= axi_lite.wdata;
        w_strb_q <= axi_lite.wstrb;
      end
      w_cnt <= (w_state == W_DELAY) ? w_cnt + 4'd1 : 4'd0;
      if (wr_commit) bresp_q <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
      if ((w_state == W_RESP) && axi_lite.bready) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_commit && wr_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = (WAIT_STATES == 0) ? R_RESP : R_DELAY;
      R_DELAY: if (r_cnt == WS_LAST) r_next = R_RESP;
      R_RESP:  if (axi_lite.rready)  r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    arready = 1'b0;
    rvalid  = 1'b0;
    if (!rst) begin
      arready = (r_state == R_IDLE);
      rvalid  = (r_state == R_RESP);
    end
  end

  // Same-edge read and write of one word returns the pre-write contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      ar_addr_q <= 32'd0;
      r_cnt     <= 4'd0;
      rdata_q   <= 32'd0;
      rresp_q   <= RESP_OKAY;
    end else begin
      if (ar_hs) ar_addr_q <= axi_lite.araddr;
      r_cnt <= (r_state == R_DELAY) ? r_cnt + 4'd1 : 4'd0;
      if (rd_commit) begin
        rdata_q <= rd_in_range ? mem[rd_idx] : 32'd0;
        rresp_q <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign axi_lite.awready = awready;
  assign axi_lite.wready  = wready;
  assign axi_lite.bvalid  = bvalid;
  assign axi_lite.bresp   = rst ? 2'b00 : bresp_q;
  assign axi_lite.arready = arready;
  assign axi_lite.rvalid  = rvalid;
  assign axi_lite.rresp   = rst ? 2'b00 : rresp_q;
  assign axi_lite.rdata   = rst ? 32'd0 : rdata_q;
endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// tb/tb_axi_lite_sram_slave.sv - scoreboard bench for axi_lite_sram_slave
// dut0 runs with no wait states, dut3 with three; sel picks which one the stimulus drives.
module tb_axi_lite_sram_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

`ifdef AXI_LITE_SRAM_DECERR_EN
  localparam logic [1:0]  ERR      = 2'b10;
  localparam logic [31:0] OOR_DATA = 32'h0000_0000;
  localparam logic [31:0] W0_AFTER = 32'h1234_5678;
`else
  localparam logic [1:0]  ERR      = 2'b00;
  localparam logic [31:0] OOR_DATA = 32'h7777_7777;
  localparam logic [31:0] W0_AFTER = 32'h7777_7777;
`endif

  logic        sel;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  axi_lite_sram_slave_if bus0();
  axi_lite_sram_slave_if bus3();

  assign bus0.awaddr  = awaddr;   assign bus3.awaddr  = awaddr;
  assign bus0.wdata   = wdata;    assign bus3.wdata   = wdata;
  assign bus0.wstrb   = wstrb;    assign bus3.wstrb   = wstrb;
  assign bus0.araddr  = araddr;   assign bus3.araddr  = araddr;
  assign bus0.awvalid = awvalid && !sel;  assign bus3.awvalid = awvalid && sel;
  assign bus0.wvalid  = wvalid && !sel;   assign bus3.wvalid  = wvalid && sel;
  assign bus0.bready  = bready && !sel;   assign bus3.bready  = bready && sel;
  assign bus0.arvalid = arvalid && !sel;  assign bus3.arvalid = arvalid && sel;
  assign bus0.rready  = rready && !sel;   assign bus3.rready  = rready && sel;

  assign awready = sel ? bus3.awready : bus0.awready;
  assign wready  = sel ? bus3.wready  : bus0.wready;
  assign bvalid  = sel ? bus3.bvalid  : bus0.bvalid;
  assign bresp   = sel ? bus3.bresp   : bus0.bresp;
  assign arready = sel ? bus3.arready : bus0.arready;
  assign rvalid  = sel ? bus3.rvalid  : bus0.rvalid;
  assign rresp   = sel ? bus3.rresp   : bus0.rresp;
  assign rdata   = sel ? bus3.rdata   : bus0.rdata;

  axi_lite_sram_slave #(.BASE_ADDR(32'h0), .DEPTH(16), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .axi_lite(bus0)
  );
  axi_lite_sram_slave #(.BASE_ADDR(32'h0), .DEPTH(16), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .axi_lite(bus3)
  );

  logic [1:0]  bq[$];
  logic [33:0] rq[$];
  logic [1:0]  exp_b;
  logic [33:0] exp_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tmo(input string name);
    checks++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  always @(negedge clk) begin
    if (!rst && bvalid && bready) begin
      if (bq.size() == 0) begin
        checks++;
        $display("FAIL b_unexpected: got bresp %h expected no response", bresp);
      end else begin
        exp_b = bq.pop_front();
        chk("bresp", 32'(bresp), 32'(exp_b));
      end
    end
    if (!rst && rvalid && rready) begin
      if (rq.size() == 0) begin
        checks++;
        $display("FAIL r_unexpected: got rdata %h expected no response", rdata);
      end else begin
        exp_r = rq.pop_front();
        chk("rresp", 32'(rresp), 32'(exp_r[33:32]));
        chk("rdata", rdata, exp_r[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] resp, output int lat);
    logic ah, wh;
    int   n;
    bq.push_back(resp);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; n = 0;
    while ((awvalid || wvalid) && n < 40) begin
      ah = awvalid && awready;
      wh = wvalid && wready;
      tick();
      if (ah) awvalid = 1'b0;
      if (wh) wvalid  = 1'b0;
      n++;
    end
    if (awvalid || wvalid) begin
      tmo("wr_aw_w");
      awvalid = 1'b0; wvalid = 1'b0;
    end
    lat = 0;
    while (!bvalid && lat < 40) begin tick(); lat++; end
    if (!bvalid) tmo("wr_bvalid");
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp,
                    input int hold, output int lat);
    logic        ah;
    logic [31:0] held;
    int          n;
    rq.push_back({resp, d});
    araddr = a; arvalid = 1'b1; n = 0;
    while (arvalid && n < 40) begin
      ah = arvalid && arready;
      tick();
      if (ah) arvalid = 1'b0;
      n++;
    end
    if (arvalid) begin tmo("rd_ar"); arvalid = 1'b0; end
    lat = 0;
    while (!rvalid && lat < 40) begin tick(); lat++; end
    if (!rvalid) tmo("rd_rvalid");
    held = rdata;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("r_hold_rvalid", 32'(rvalid), 32'd1);
      chk("r_hold_rdata", rdata, held);
      chk("r_hold_arready", 32'(arready), 32'd0);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    sel = 1'b0;
    awaddr = '0; wdata = '0; araddr = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_awready0", 32'(bus0.awready), 32'd0);
    chk("rst_wready0",  32'(bus0.wready),  32'd0);
    chk("rst_arready0", 32'(bus0.arready), 32'd0);
    chk("rst_bvalid3",  32'(bus3.bvalid),  32'd0);
    chk("rst_rvalid3",  32'(bus3.rvalid),  32'd0);
    chk("rst_rdata0",   bus0.rdata,        32'd0);
    rst = 1'b0;
    tick();
    chk("idle_awready", 32'(awready), 32'd1);
    chk("idle_arready", 32'(arready), 32'd1);

    wr(32'h10, 32'hDEAD_BEEF, 4'hF, 2'b00, lat);
    chk("t1_wr_lat", 32'(lat), 32'd0);
    rd(32'h10, 32'hDEAD_BEEF, 2'b00, 0, lat);
    chk("t1_rd_lat", 32'(lat), 32'd0);

    // W three cycles ahead of AW, then B back-pressure
    bq.push_back(2'b00);
    awaddr = 32'h14; wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
    chk("t2_wready_idle", 32'(wready), 32'd1);
    tick();
    wvalid = 1'b0;
    repeat (2) begin
      chk("t2_wready_low", 32'(wready), 32'd0);
      chk("t2_awready_hi", 32'(awready), 32'd1);
      tick();
    end
    awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    repeat (4) begin
      chk("t2_bvalid_hold", 32'(bvalid), 32'd1);
      chk("t2_awready_busy", 32'(awready), 32'd0);
      chk("t2_wready_busy", 32'(wready), 32'd0);
      tick();
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("t2_awready_back", 32'(awready), 32'd1);
    rd(32'h14, 32'hCAFE_F00D, 2'b00, 0, lat);

    wr(32'h20, 32'h1122_3344, 4'hF, 2'b00, lat);
    wr(32'h20, 32'hAABB_CCDD, 4'b0101, 2'b00, lat);
    rd(32'h20, 32'h11BB_33DD, 2'b00, 0, lat);
    wr(32'h20, 32'hFFFF_FFFF, 4'b0000, 2'b00, lat);
    rd(32'h20, 32'h11BB_33DD, 2'b00, 0, lat);

    sel = 1'b1;
    tick();
    wr(32'h10, 32'hDEAD_BEEF, 4'hF, 2'b00, lat);
    chk("t4_wr_lat", 32'(lat), 32'd3);
    rd(32'h10, 32'hDEAD_BEEF, 2'b00, 2, lat);
    chk("t4_rd_lat", 32'(lat), 32'd3);

    // Reset lands while the write sits in W_DELAY
    wr(32'h18, 32'h0000_0001, 4'hF, 2'b00, lat);
    awaddr = 32'h18; wdata = 32'h0000_0099; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    chk("t5_delay_bvalid", 32'(bvalid), 32'd0);
    rst = 1'b1;
    tick();
    chk("t5_rst_awready", 32'(awready), 32'd0);
    rst = 1'b0;
    tick();
    chk("t5_idle_awready", 32'(awready), 32'd1);
    chk("t5_idle_wready", 32'(wready), 32'd1);
    repeat (4) tick();
    chk("t5_no_bvalid", 32'(bvalid), 32'd0);
    rd(32'h18, 32'h0000_0001, 2'b00, 0, lat);

    sel = 1'b0;
    tick();
    wr(32'h30, 32'h0, 4'hF, 2'b00, lat);
    bq.push_back(2'b00);
    rq.push_back({2'b00, 32'h0});
    awaddr = 32'h30; wdata = 32'h5; wstrb = 4'hF; araddr = 32'h30;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    chk("t5_all_ready", 32'({awready, wready, arready}), 32'd7);
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("t5_same_bvalid", 32'(bvalid), 32'd1);
    chk("t5_same_rvalid", 32'(rvalid), 32'd1);
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    rd(32'h30, 32'h5, 2'b00, 0, lat);

    wr(32'h00, 32'h1234_5678, 4'hF, 2'b00, lat);
    wr(32'h40, 32'h7777_7777, 4'hF, ERR, lat);
    rd(32'h40, OOR_DATA, ERR, 0, lat);
    rd(32'h00, W0_AFTER, 2'b00, 0, lat);

    repeat (3) tick();
    chk("bq_empty", 32'(bq.size()), 32'd0);
    chk("rq_empty", 32'(rq.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
